// File: rtl/chunked_add_sequencer_if.sv
// chunked_add_sequencer_if: operand/result handshake bundle for the chunked adder.
interface chunked_add_sequencer_if #(
  parameter int DATA_WIDTH = 10,
  parameter int NUM_CHUNKS = 4
);
  localparam int W = DATA_WIDTH * NUM_CHUNKS;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum;
  logic         busy;
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, busy
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, busy
  );
endinterface

// File: rtl/chunked_add_sequencer.sv
// chunked_add_sequencer: multi-cycle wide adder, one DATA_WIDTH chunk per cycle, LSB chunk first.
module chunked_add_sequencer #(
  parameter int DATA_WIDTH = 10,
  parameter int NUM_CHUNKS = 4
) (
  input logic                    clk,
  input logic                    reset,
  chunked_add_sequencer_if.slave bus
);
  localparam int W  = DATA_WIDTH * NUM_CHUNKS;
  localparam int IW = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [W:0] LOW = {{(W + 1 - DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t              state_q, state_d;
  logic [W-1:0]        a_q, a_d, b_q, b_d;
  logic [W:0]          sum_q, sum_d;
  logic                carry_q, carry_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [31:0]         off;
  logic [W-1:0]        a_sh, b_sh;
  logic [DATA_WIDTH:0] chunk;
  logic                last;
  // Shifts instead of indexed part-selects keep every chunk position in range for any NUM_CHUNKS.
  assign off   = 32'(idx_q) * 32'(DATA_WIDTH);
  assign a_sh  = a_q >> off;
  assign b_sh  = b_q >> off;
  assign chunk = {1'b0, a_sh[DATA_WIDTH-1:0]} + {1'b0, b_sh[DATA_WIDTH-1:0]} + (DATA_WIDTH + 1)'(carry_q);
  assign last  = idx_q == IW'(NUM_CHUNKS - 1);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        a_d     = bus.a;
        b_d     = bus.b;
        carry_d = bus.cin;
        idx_d   = '0;
        state_d = ADD;
      end
      ADD: begin
        sum_d   = (sum_q & ~(LOW << off)) | ((W + 1)'(chunk[DATA_WIDTH-1:0]) << off);
        carry_d = chunk[DATA_WIDTH];
        idx_d   = last ? '0 : idx_q + 1'b1;
        if (last) begin
          sum_d[W] = chunk[DATA_WIDTH];
          state_d  = DONE;
        end
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end
  assign bus.in_ready  = state_q == IDLE && !reset;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy      = state_q != IDLE;
  assign bus.sum       = sum_q;
endmodule

// File: tb/tb_chunked_add_sequencer.sv
// tb_chunked_add_sequencer: directed handshake/latency tests plus randomized scoreboard runs on three configurations.
module tb_chunked_add_sequencer;
  logic clk = 0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic rand_go = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  logic rst;
  chunked_add_sequencer_if #(.DATA_WIDTH(10), .NUM_CHUNKS(4)) dbus ();
  chunked_add_sequencer #(.DATA_WIDTH(10), .NUM_CHUNKS(4)) dut (.clk(clk), .reset(rst), .bus(dbus));
  logic [40:0] dq[$];
  task automatic op(input logic [39:0] a, input logic [39:0] b, input logic c, input int hold);
    logic [40:0] exp;
    int n;
    check("idle_in_ready", dbus.in_ready, 1);
    dbus.a = a;
    dbus.b = b;
    dbus.cin = c;
    dbus.in_valid = 1;
    dbus.out_ready = 0;
    dq.push_back({1'b0, a} + {1'b0, b} + 41'(c));
    tick();
    dbus.in_valid = 0;
    dbus.a = ~a;
    dbus.b = ~b;
    dbus.cin = ~c;
    n = 0;
    while (!dbus.out_valid && n < 20) begin
      check("add_busy", dbus.busy, 1);
      check("add_in_ready", dbus.in_ready, 0);
      tick();
      n++;
    end
    check("latency", n, 4);
    exp = dq.pop_front();
    check("sum", dbus.sum, exp);
    for (int i = 0; i < hold; i++) begin
      dbus.in_valid = i[0];
      dbus.a = 40'($urandom());
      dbus.b = 40'($urandom());
      tick();
      check("hold_out_valid", dbus.out_valid, 1);
      check("hold_sum", dbus.sum, exp);
      check("hold_in_ready", dbus.in_ready, 0);
    end
    dbus.in_valid = 0;
    dbus.out_ready = 1;
    tick();
    check("drop_out_valid", dbus.out_valid, 0);
    check("back_in_ready", dbus.in_ready, 1);
    dbus.out_ready = 0;
  endtask
  initial begin
    int acc[$];
    int ov[$];
    rst = 1;
    dbus.in_valid = 0;
    dbus.a = '0;
    dbus.b = '0;
    dbus.cin = 0;
    dbus.out_ready = 0;
    tick();
    tick();
    check("rst_in_ready", dbus.in_ready, 0);
    check("rst_out_valid", dbus.out_valid, 0);
    check("rst_busy", dbus.busy, 0);
    check("rst_sum", dbus.sum, 0);
    rst = 0;
    tick();
    check("post_rst_in_ready", dbus.in_ready, 1);
    op(40'hFF_FFFF_FFFF, 40'h1, 1'b0, 0);
    op(40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b1, 0);
    op(40'h0, 40'h0, 1'b1, 0);
    op(40'h12_3456_789A, 40'h0F_0F0F_0F0F, 1'b1, 5);
    // Abort during the third ADD cycle: no result may ever appear for this operand set.
    dbus.a = 40'h12_3456_789A;
    dbus.b = 40'h1;
    dbus.cin = 0;
    dbus.in_valid = 1;
    tick();
    dbus.in_valid = 0;
    tick();
    tick();
    rst = 1;
    tick();
    check("abort_out_valid", dbus.out_valid, 0);
    check("abort_busy", dbus.busy, 0);
    check("abort_sum", dbus.sum, 0);
    check("abort_in_ready", dbus.in_ready, 0);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_valid", dbus.out_valid, 0);
    end
    op(40'h3FF, 40'h1, 1'b0, 0);
    dbus.a = 40'h55_5555_5555;
    dbus.b = 40'h2A_AAAA_AAAB;
    dbus.cin = 0;
    dbus.in_valid = 1;
    dbus.out_ready = 1;
    for (int c = 0; c < 18; c++) begin
      if (dbus.in_ready) acc.push_back(c);
      if (dbus.out_valid) begin
        ov.push_back(c);
        check("stream_sum", dbus.sum, 41'h80_0000_0000);
      end
      if (c == 13) dbus.in_valid = 0;
      tick();
    end
    dbus.out_ready = 0;
    check("stream_accepts", acc.size(), 3);
    check("stream_results", ov.size(), 3);
    if (acc.size() == 3 && ov.size() == 3) begin
      check("stream_spacing0", acc[1] - acc[0], 6);
      check("stream_spacing1", acc[2] - acc[1], 6);
      check("stream_latency0", ov[0] - acc[0], 5);
      check("stream_latency2", ov[2] - acc[2], 5);
    end
    rand_go = 1;
    for (int i = 0; i < 80000 && !(cfg[0].done && cfg[1].done && cfg[2].done); i++) tick();
    if (!(cfg[0].done && cfg[1].done && cfg[2].done)) check("rand_timeout", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int DW = g == 2 ? 8 : 10;
    localparam int NC = g == 0 ? 4 : g == 1 ? 1 : 3;
    localparam int W  = DW * NC;
    logic r_rst;
    logic done = 0;
    logic drv_done = 0;
    int got = 0;
    logic [W:0] q[$];
    chunked_add_sequencer_if #(.DATA_WIDTH(DW), .NUM_CHUNKS(NC)) bus ();
    chunked_add_sequencer #(.DATA_WIDTH(DW), .NUM_CHUNKS(NC)) dut (.clk(clk), .reset(r_rst), .bus(bus));
    function automatic logic [W-1:0] rnd();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return $urandom_range(0, 3) == 0 ? '1 : $urandom_range(0, 3) == 0 ? '0 : r[W-1:0];
    endfunction
    initial begin : drv
      int gap;
      int w;
      logic rdy;
      r_rst = 1;
      bus.in_valid = 0;
      bus.a = '0;
      bus.b = '0;
      bus.cin = 0;
      wait (rand_go);
      tick();
      r_rst = 0;
      tick();
      for (int n = 0; n < 1000; n++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) tick();
        bus.a = rnd();
        bus.b = rnd();
        bus.cin = 1'($urandom_range(0, 1));
        bus.in_valid = 1;
        w = 0;
        do begin
          rdy = bus.in_ready;
          tick();
          w++;
        end while (!rdy && w < 50);
        if (!rdy) begin
          check("rand_accept_timeout", 0, 1);
          break;
        end
        q.push_back({1'b0, bus.a} + {1'b0, bus.b} + (W + 1)'(bus.cin));
        bus.in_valid = 0;
        bus.a = ~bus.a;
        bus.b = rnd();
      end
      drv_done = 1;
    end
    initial begin : mon
      int cyc;
      cyc = 0;
      bus.out_ready = 0;
      wait (rand_go);
      while (!(drv_done && q.size() == 0) && cyc < 60000) begin
        tick();
        cyc++;
        bus.out_ready = 1'($urandom_range(0, 1));
        if (bus.out_valid && bus.out_ready) begin
          got++;
          if (q.size() == 0) check("rand_spurious_valid", 0, 1);
          else check("rand_sum", 64'(bus.sum), 64'(q.pop_front()));
        end
      end
      check("rand_handshakes", got, 1000);
      done = 1;
    end
  end
endmodule
